// File: rtl/ysyx_23060077_mem_arbiter.sv
// Two-master (IFU/LSU) to single memory port arbiter with one outstanding transaction.
// LSU has fixed priority; the response is routed back to whichever master issued the request.
module ysyx_23060077_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic                    lsu_wen,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wstrb,
    output logic                    lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_wen,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    logic [1:0]            state_q,     state_d;
    logic                  owner_q,     owner_d;
    logic                  wen_q,       wen_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,     wstrb_d;
    logic [DATA_WIDTH-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_WIDTH-1:0] lsu_rdata_q, lsu_rdata_d;

    logic is_idle;
    logic lsu_fire;
    logic ifu_fire;

    assign is_idle = (state_q == S_IDLE);

    // Gated by rst_n so that no master sees a grant while reset is held.
    assign lsu_req_ready = rst_n & is_idle & lsu_req_valid;
    assign ifu_req_ready = rst_n & is_idle & ifu_req_valid & ~lsu_req_valid;

    assign lsu_fire = lsu_req_ready;
    assign ifu_fire = ifu_req_ready;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_fire) begin
                    state_d = S_REQ;
                    owner_d = OWNER_LSU;
                    wen_d   = lsu_wen;
                    addr_d  = lsu_addr;
                    wdata_d = lsu_wdata;
                    // Loads never carry byte enables to memory.
                    wstrb_d = lsu_wen ? lsu_wstrb : '0;
                end else if (ifu_fire) begin
                    state_d = S_REQ;
                    owner_d = OWNER_IFU;
                    wen_d   = 1'b0;
                    addr_d  = ifu_addr;
                    wdata_d = '0;
                    wstrb_d = '0;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = S_RESP;
                    if (owner_q == OWNER_LSU) begin
                        lsu_rdata_d = wen_q ? '0 : mem_rdata;
                    end else begin
                        ifu_rdata_d = mem_rdata;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWNER_IFU;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign mem_req_valid  = (state_q == S_REQ);
    assign mem_wen        = wen_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wstrb      = wstrb_q;

    assign ifu_resp_valid = (state_q == S_RESP) & (owner_q == OWNER_IFU);
    assign lsu_resp_valid = (state_q == S_RESP) & (owner_q == OWNER_LSU);
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_ysyx_23060077_mem_arbiter.sv
// Directed bench for ysyx_23060077_mem_arbiter: a vector table of single transactions
// plus hand-written sequences for contention, reset mid-transaction and spurious responses.
module tb_ysyx_23060077_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_ifu = '0;
    logic [31:0] last_lsu = '0;

    always #5 clk = ~clk;

    ysyx_23060077_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_wen        (lsu_wen),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_wstrb      (lsu_wstrb),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    typedef struct {
        logic        lsu;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          delay;
        logic        spur;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts at the negedge following the fire edge and runs through REQ/WAIT/RESP to IDLE.
    task automatic complete_txn(input vec_t v);
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        exp_wstrb = (v.lsu && v.wen) ? v.wstrb : 4'h0;
        exp_wdata = v.lsu ? v.wdata : 32'h0;
        for (int k = 0; k <= v.delay; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (v.lsu) lsu_req_valid = 1'b0;
                else       ifu_req_valid = 1'b0;
            end
            mem_req_ready  = (k == v.delay);
            mem_resp_valid = v.spur && (k != v.delay);
            mem_rdata      = 32'hBAD0_0000 | k;
            #1;
            chk("req_valid", mem_req_valid, 1'b1);
            chk("req_wen", mem_wen, v.lsu & v.wen);
            chk("req_addr", mem_addr, v.addr);
            chk("req_wstrb", mem_wstrb, exp_wstrb);
            if (!(v.lsu && !v.wen)) chk("req_wdata", mem_wdata, exp_wdata);
            chk("req_ifu_ready", ifu_req_ready, 1'b0);
            chk("req_lsu_ready", lsu_req_ready, 1'b0);
            chk("req_ifu_resp", ifu_resp_valid, 1'b0);
            chk("req_lsu_resp", lsu_resp_valid, 1'b0);
        end
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = v.rdata;
        #1;
        chk("wait_req_valid", mem_req_valid, 1'b0);
        chk("wait_ifu_resp", ifu_resp_valid, 1'b0);
        chk("wait_lsu_resp", lsu_resp_valid, 1'b0);
        @(negedge clk);
        mem_resp_valid = v.spur;
        mem_rdata      = ~v.rdata;
        #1;
        chk("resp_ifu_valid", ifu_resp_valid, !v.lsu);
        chk("resp_lsu_valid", lsu_resp_valid, v.lsu);
        chk("resp_ifu_ready", ifu_req_ready, 1'b0);
        if (v.lsu) last_lsu = v.exp_rdata;
        else       last_ifu = v.exp_rdata;
        chk("resp_ifu_rdata", ifu_rdata, last_ifu);
        chk("resp_lsu_rdata", lsu_rdata, last_lsu);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("idle_ifu_resp", ifu_resp_valid, 1'b0);
        chk("idle_lsu_resp", lsu_resp_valid, 1'b0);
        chk("idle_req_valid", mem_req_valid, 1'b0);
        chk("hold_ifu_rdata", ifu_rdata, last_ifu);
        chk("hold_lsu_rdata", lsu_rdata, last_lsu);
        $display("txn lsu=%0d wen=%0d addr=%h rdata_exp=%h delay=%0d spur=%0d",
                 v.lsu, v.wen, v.addr, v.exp_rdata, v.delay, v.spur);
    endtask

    task automatic do_txn(input vec_t v);
        @(negedge clk);
        if (v.lsu) begin
            lsu_req_valid = 1'b1;
            lsu_wen       = v.wen;
            lsu_addr      = v.addr;
            lsu_wdata     = v.wdata;
            lsu_wstrb     = v.wstrb;
        end else begin
            ifu_req_valid = 1'b1;
            ifu_addr      = v.addr;
        end
        // Spurious handshake inputs while IDLE must be ignored.
        mem_req_ready  = v.spur;
        mem_resp_valid = v.spur;
        #1;
        chk("grant_ifu_ready", ifu_req_ready, !v.lsu);
        chk("grant_lsu_ready", lsu_req_ready, v.lsu);
        chk("grant_no_resp", ifu_resp_valid | lsu_resp_valid, 1'b0);
        complete_txn(v);
    endtask

    initial begin
        vec_t lv;
        vec_t iv;

        vecs[0] = '{lsu:1'b0, wen:1'b0, addr:32'h8000_0000, wdata:32'h0, wstrb:4'h0,
                    rdata:32'h0000_0413, delay:0, spur:1'b0, exp_rdata:32'h0000_0413};
        vecs[1] = '{lsu:1'b1, wen:1'b1, addr:32'h8000_1000, wdata:32'hdead_beef, wstrb:4'hF,
                    rdata:32'hCAFE_F00D, delay:5, spur:1'b0, exp_rdata:32'h0};
        vecs[2] = '{lsu:1'b1, wen:1'b0, addr:32'h8000_2000, wdata:32'h1111_1111, wstrb:4'hF,
                    rdata:32'h1234_5678, delay:0, spur:1'b0, exp_rdata:32'h1234_5678};
        vecs[3] = '{lsu:1'b0, wen:1'b0, addr:32'h8000_0004, wdata:32'h0, wstrb:4'h0,
                    rdata:32'h0010_0093, delay:2, spur:1'b0, exp_rdata:32'h0010_0093};
        vecs[4] = '{lsu:1'b1, wen:1'b1, addr:32'h8000_1003, wdata:32'h0000_00AB, wstrb:4'h8,
                    rdata:32'h7777_7777, delay:1, spur:1'b0, exp_rdata:32'h0};
        vecs[5] = '{lsu:1'b0, wen:1'b0, addr:32'h8000_0008, wdata:32'h0, wstrb:4'h0,
                    rdata:32'h0000_0013, delay:2, spur:1'b1, exp_rdata:32'h0000_0013};

        rst_n          = 1'b0;
        ifu_req_valid  = 1'b0;
        ifu_addr       = '0;
        lsu_req_valid  = 1'b0;
        lsu_wen        = 1'b0;
        lsu_addr       = '0;
        lsu_wdata      = '0;
        lsu_wstrb      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        chk("rst_rdata", {ifu_rdata, lsu_rdata}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i]);
        end

        // Both masters request in the same IDLE cycle: LSU wins, IFU follows right after.
        lv = '{lsu:1'b1, wen:1'b0, addr:32'h8000_3000, wdata:32'h0, wstrb:4'hF,
               rdata:32'h0000_00FF, delay:0, spur:1'b0, exp_rdata:32'h0000_00FF};
        iv = '{lsu:1'b0, wen:1'b0, addr:32'h8000_000C, wdata:32'h0, wstrb:4'h0,
               rdata:32'h0000_0513, delay:0, spur:1'b0, exp_rdata:32'h0000_0513};
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_wen       = lv.wen;
        lsu_addr      = lv.addr;
        lsu_wdata     = lv.wdata;
        lsu_wstrb     = lv.wstrb;
        ifu_req_valid = 1'b1;
        ifu_addr      = iv.addr;
        #1;
        chk("both_lsu_ready", lsu_req_ready, 1'b1);
        chk("both_ifu_ready", ifu_req_ready, 1'b0);
        complete_txn(lv);
        chk("after_lsu_ifu_ready", ifu_req_ready, 1'b1);
        complete_txn(iv);

        // Spurious responses in IDLE produce nothing.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'hFFFF_0000;
            #1;
            chk("idle_spur_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("idle_spur_after", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        chk("idle_spur_rdata", {ifu_rdata, lsu_rdata}, {last_ifu, last_lsu});

        // Reset asserted while waiting for the memory response.
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 32'h8000_4000;
        lsu_wstrb     = 4'hF;
        #1;
        chk("rstw_grant", lsu_req_ready, 1'b1);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("rstw_req_valid", mem_req_valid, 1'b1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("rstw_req_valid0", mem_req_valid, 1'b0);
        chk("rstw_mem_addr0", mem_addr, 32'h0);
        chk("rstw_mem_fields0", {mem_wen, mem_wdata, mem_wstrb}, 37'h0);
        chk("rstw_resp0", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        chk("rstw_rdata0", {ifu_rdata, lsu_rdata}, 64'h0);
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0055;
        #1;
        chk("rstw_resp_in_rst", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("rstw_no_pulse", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        chk("rstw_req_idle", mem_req_valid, 1'b0);
        chk("rstw_lsu_rdata", lsu_rdata, 32'h0);
        last_ifu = '0;
        last_lsu = '0;
        do_txn(vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
